// File: rtl/ws2812_pkg.sv
// ws2812_pkg
// Shared definitions for the WS2812 frame path: pixel/channel widths,
// serializer bit timing constants (in 48 MHz clock cycles), the frame
// sequencer state encoding and the per-channel brightness scale function.
package ws2812_pkg;

  localparam int PIXEL_W  = 24;
  localparam int CHAN_W   = 8;
  localparam int T_PERIOD = 60;
  localparam int T0_ON    = 17;
  localparam int T1_ON    = 34;
  localparam int T_RESET  = 3120;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    STREAM,
    TAIL
  } seq_state_t;

  // (c * (b + 1)) >> 8 : b = 255 is identity, b = 0 yields 0.
  // The product tops out at 255 * 256, so 16 bits are enough.
  function automatic logic [CHAN_W-1:0] scale_chan(input logic [CHAN_W-1:0] c,
                                                    input logic [CHAN_W-1:0] b);
    logic [2*CHAN_W-1:0] prod;
    prod = 16'(c) * (16'(b) + 16'd1);
    return prod[2*CHAN_W-1:CHAN_W];
  endfunction

endpackage

// File: rtl/ws2812_pixel_scaler.sv
// ws2812_pixel_scaler
// Applies the global brightness to all three channels of a pixel in one
// registered stage. The output register only loads when en is high, so the
// serializer sees a value that is stable between pixel updates.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset (output clears to 0)
//   en             load the scaled pixel this cycle
//   pixel_in       24-bit pixel, wire order
//   brightness     8-bit scale factor
//   pixel_out      registered scaled pixel
module ws2812_pixel_scaler
  import ws2812_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic [PIXEL_W-1:0] pixel_in,
  input  logic [CHAN_W-1:0]  brightness,
  output logic [PIXEL_W-1:0] pixel_out
);

  logic [PIXEL_W-1:0] scaled_next;
  logic [PIXEL_W-1:0] pixel_reg;

  genvar gi;
  generate
    for (gi = 0; gi < PIXEL_W / CHAN_W; gi++) begin : g_chan
      assign scaled_next[gi*CHAN_W +: CHAN_W] =
        scale_chan(pixel_in[gi*CHAN_W +: CHAN_W], brightness);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_reg <= '0;
    end else if (en) begin
      pixel_reg <= scaled_next;
    end
  end

  assign pixel_out = pixel_reg;

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// ws2812_frame_sequencer
// Frame controller in front of the WS2812 serializer. Holds a NUM_LEDS-deep
// pixel store written by the host, latches a global brightness at frame
// start and drives the serializer's send_n / rgb_data / new_data_req
// handshake so exactly NUM_LEDS pixels go out per frame, followed by a
// TAIL_CYCLES guard period.
// Optional build macro: WS2812_DOUBLE_BUFFER_EN -- two pixel banks; host
// writes land in the back bank, banks swap at frame accept and the new front
// is copied into the back bank in the background, giving tear-free frames.
// Ports:
//   clk, reset_n        48 MHz clock, asynchronous active-low reset
//   pix_we/addr/wdata   host pixel write (addr >= NUM_LEDS ignored)
//   brightness          global scale, sampled at frame accept
//   start               one-cycle frame trigger (one-deep pending while busy)
//   busy                frame in progress incl. load and tail
//   frame_done          one-cycle pulse at end of tail
//   rgb_data            scaled pixel to serializer
//   send_n              active-low "more pixels" to serializer
//   new_data_req        serializer pulse at the start of each pixel
module ws2812_frame_sequencer
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS    = 8,
  parameter int TAIL_CYCLES = 1500,
  parameter int ADDR_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pix_we,
  input  logic [ADDR_W-1:0]  pix_addr,
  input  logic [PIXEL_W-1:0] pix_wdata,
  input  logic [CHAN_W-1:0]  brightness,
  input  logic               start,
  output logic               busy,
  output logic               frame_done,
  output logic [PIXEL_W-1:0] rgb_data,
  output logic               send_n,
  input  logic               new_data_req
);

  localparam int TAIL_W = $clog2(TAIL_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);

  seq_state_t          state_reg, state_next;
  logic [ADDR_W-1:0]   idx_reg, idx_next;
  logic                load_cnt_reg, load_cnt_next;
  logic [TAIL_W-1:0]   tail_cnt_reg, tail_cnt_next;
  logic [CHAN_W-1:0]   bright_q_reg, bright_q_next;
  logic                pending_reg, pending_next;
  logic                busy_reg, busy_next;
  logic                frame_done_reg, frame_done_next;
  logic                send_n_reg, send_n_next;
  logic                new_data_req_q;
  logic                req_rise;
  logic                accept;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_valid_reg;
  logic [PIXEL_W-1:0]  rd_data_reg;
  logic                host_we;

  assign req_rise = new_data_req & ~new_data_req_q;
  assign host_we  = pix_we && ({1'b0, pix_addr} < (ADDR_W + 1)'(NUM_LEDS));

  // ---------------------------------------------------------------- store
`ifdef WS2812_DOUBLE_BUFFER_EN
  localparam int MEM_AW = ADDR_W + 1;

  logic                front_bank_reg;
  logic                copy_active_reg;
  logic [ADDR_W-1:0]   copy_idx_reg;
  logic                rd_bank;
  logic [PIXEL_W-1:0]  pix_mem [2*NUM_LEDS];

  function automatic logic [MEM_AW-1:0] bank_addr(input logic bank,
                                                  input logic [ADDR_W-1:0] a);
    return bank ? (MEM_AW'(NUM_LEDS) + MEM_AW'(a)) : MEM_AW'(a);
  endfunction

  // The pixel-0 read issued at accept must already see the swapped front.
  assign rd_bank = accept ? ~front_bank_reg : front_bank_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      front_bank_reg  <= 1'b0;
      copy_active_reg <= 1'b0;
      copy_idx_reg    <= '0;
    end else if (accept) begin
      front_bank_reg  <= ~front_bank_reg;
      copy_active_reg <= 1'b1;
      copy_idx_reg    <= '0;
    end else if (copy_active_reg) begin
      if (copy_idx_reg == LAST_IDX) begin
        copy_active_reg <= 1'b0;
      end else begin
        copy_idx_reg <= copy_idx_reg + 1'b1;
      end
    end
  end

  // Copy-forward owns the back-bank slot it touches this cycle; a host write
  // to that same address is dropped, writes elsewhere proceed.
  always_ff @(posedge clk) begin
    if (copy_active_reg) begin
      pix_mem[bank_addr(~front_bank_reg, copy_idx_reg)] <=
        pix_mem[bank_addr(front_bank_reg, copy_idx_reg)];
    end
    if (host_we && !(copy_active_reg && pix_addr == copy_idx_reg)) begin
      pix_mem[bank_addr(~front_bank_reg, pix_addr)] <= pix_wdata;
    end
    if (rd_en) begin
      rd_data_reg <= pix_mem[bank_addr(rd_bank, rd_addr)];
    end
  end
`else
  logic [PIXEL_W-1:0]  pix_mem [NUM_LEDS];

  always_ff @(posedge clk) begin
    if (host_we) begin
      pix_mem[pix_addr] <= pix_wdata;
    end
    if (rd_en) begin
      rd_data_reg <= pix_mem[rd_addr];
    end
  end
`endif

  // ---------------------------------------------------------------- scaler
  ws2812_pixel_scaler u_scaler (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (rd_valid_reg),
    .pixel_in   (rd_data_reg),
    .brightness (bright_q_reg),
    .pixel_out  (rgb_data)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      load_cnt_reg   <= 1'b0;
      tail_cnt_reg   <= '0;
      bright_q_reg   <= '0;
      pending_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      send_n_reg     <= 1'b1;
      new_data_req_q <= 1'b0;
      rd_valid_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      load_cnt_reg   <= load_cnt_next;
      tail_cnt_reg   <= tail_cnt_next;
      bright_q_reg   <= bright_q_next;
      pending_reg    <= pending_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
      send_n_reg     <= send_n_next;
      new_data_req_q <= new_data_req;
      rd_valid_reg   <= rd_en;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    load_cnt_next   = load_cnt_reg;
    tail_cnt_next   = tail_cnt_reg;
    bright_q_next   = bright_q_reg;
    pending_next    = pending_reg;
    busy_next       = busy_reg;
    frame_done_next = 1'b0;
    send_n_next     = 1'b1;
    accept          = 1'b0;
    rd_en           = 1'b0;
    rd_addr         = idx_reg;

    // Any start outside IDLE (including the last tail cycle) queues one frame.
    if (start && state_reg != IDLE) begin
      pending_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (start || pending_reg) begin
          accept        = 1'b1;
          bright_q_next = brightness;
          idx_next      = '0;
          busy_next     = 1'b1;
          pending_next  = 1'b0;
          rd_en         = 1'b1;
          rd_addr       = '0;
          load_cnt_next = 1'b0;
          state_next    = LOAD;
        end
      end
      LOAD: begin
        // Cycle 0: read lands; cycle 1: scaled pixel 0 sits on rgb_data.
        if (load_cnt_reg) begin
          state_next = ARM;
        end else begin
          load_cnt_next = 1'b1;
        end
      end
      ARM: begin
        send_n_next = 1'b0;
        if (req_rise) begin
          if (NUM_LEDS == 1) begin
            send_n_next   = 1'b1;
            tail_cnt_next = '0;
            state_next    = TAIL;
          end else begin
            idx_next   = ADDR_W'(1);
            state_next = STREAM;
          end
        end
      end
      STREAM: begin
        send_n_next = 1'b0;
        if (req_rise) begin
          rd_en = 1'b1;
          if (idx_reg == LAST_IDX) begin
            send_n_next   = 1'b1;
            tail_cnt_next = '0;
            state_next    = TAIL;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      TAIL: begin
        if (tail_cnt_reg == TAIL_W'(TAIL_CYCLES - 1)) begin
          frame_done_next = 1'b1;
          busy_next       = 1'b0;
          state_next      = IDLE;
        end else begin
          tail_cnt_next = tail_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign send_n     = send_n_reg;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Self-checking bench for ws2812_frame_sequencer: an 8-LED instance and a
// 1-LED instance, randomized pixels/brightness against a behavioural model.
module tb_ws2812_frame_sequencer;

  localparam int N    = 8;
  localparam int TAIL = 1500;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pix_we, start, new_data_req;
  logic [2:0]  pix_addr;
  logic [23:0] pix_wdata;
  logic [7:0]  brightness;
  logic        busy, frame_done, send_n;
  logic [23:0] rgb_data;

  logic        pix_we1, start1, new_data_req1;
  logic [0:0]  pix_addr1;
  logic [23:0] pix_wdata1;
  logic [7:0]  brightness1;
  logic        busy1, frame_done1, send_n1;
  logic [23:0] rgb_data1;

  always #5 clk = ~clk;

  ws2812_frame_sequencer #(.NUM_LEDS(N), .TAIL_CYCLES(TAIL)) dut (
    .clk(clk), .reset_n(reset_n), .pix_we(pix_we), .pix_addr(pix_addr),
    .pix_wdata(pix_wdata), .brightness(brightness), .start(start),
    .busy(busy), .frame_done(frame_done), .rgb_data(rgb_data),
    .send_n(send_n), .new_data_req(new_data_req)
  );

  ws2812_frame_sequencer #(.NUM_LEDS(1), .TAIL_CYCLES(TAIL)) dut1 (
    .clk(clk), .reset_n(reset_n), .pix_we(pix_we1), .pix_addr(pix_addr1),
    .pix_wdata(pix_wdata1), .brightness(brightness1), .start(start1),
    .busy(busy1), .frame_done(frame_done1), .rgb_data(rgb_data1),
    .send_n(send_n1), .new_data_req(new_data_req1)
  );

  int checks   = 0;
  int failures = 0;

  logic [23:0] model_mem [N];
  logic [23:0] obs_rgb   [N];
  logic        obs_sendn [N];
  logic        obs_stable[N];
  int          obs_launch, obs_tail;
  logic        obs_busy_start, obs_busy_done;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: each channel c -> floor(c * (b + 1) / 256).
  function automatic logic [23:0] scale_ref(input logic [23:0] p, input logic [7:0] b);
    int k, r, g, bl;
    k  = int'(b) + 1;
    r  = (int'(p[23:16]) * k) / 256;
    g  = (int'(p[15:8])  * k) / 256;
    bl = (int'(p[7:0])   * k) / 256;
    return {r[7:0], g[7:0], bl[7:0]};
  endfunction

  task automatic write_pix(input logic [2:0] a, input logic [23:0] d);
    pix_we = 1'b1; pix_addr = a; pix_wdata = d;
    tick(1);
    pix_we = 1'b0;
    model_mem[a] = d;
  endtask

  // Emulated serializer: plays one 8-pixel frame and records what the DUT
  // presented. Optionally fires two extra starts after pixel extra_k, and
  // writes pixel 5 while idx == 2.
  task automatic play_frame(input bit with_start, input logic [7:0] b, input int extra_k,
                            input bit do_write, input logic [23:0] wdata);
    int n;
    brightness = b;
    start = with_start;
    tick(1);
    start = 1'b0;
    obs_busy_start = busy;
    brightness = 8'($urandom);
    n = 0;
    while (send_n && n < 10) begin
      tick(1);
      n++;
    end
    obs_launch = n;
    for (int k = 0; k < N; k++) begin
      new_data_req = 1'b1;
      tick(1);
      obs_sendn[k] = send_n;
      new_data_req = 1'b0;
      if (k == extra_k) begin
        start = 1'b1; tick(1); start = 1'b0; tick(1);
        start = 1'b1; tick(1); start = 1'b0;
      end else begin
        tick(3);
      end
      obs_rgb[k]    = rgb_data;
      obs_stable[k] = 1'b1;
      if (k < N - 1) begin
        for (int g = 0; g < 6; g++) begin
          if (do_write && k == 1 && g == 0) begin
            pix_we = 1'b1; pix_addr = 3'd5; pix_wdata = wdata;
          end
          tick(1);
          pix_we = 1'b0;
          if (rgb_data !== obs_rgb[k]) obs_stable[k] = 1'b0;
        end
      end
    end
    n = 3;
    while (!frame_done && n < TAIL + 20) begin
      tick(1);
      n++;
    end
    obs_tail      = n;
    obs_busy_done = busy;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick(3);
    checks += 6;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    if (rgb_data !== 24'h0) begin failures++; $display("FAIL reset_rgb: got %h expected 000000", rgb_data); end
    if (send_n !== 1'b1) begin failures++; $display("FAIL reset_send_n: got %b expected 1", send_n); end
    if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy1: got %b expected 0", busy1); end
    if (send_n1 !== 1'b1) begin failures++; $display("FAIL reset_send_n1: got %b expected 1", send_n1); end
    reset_n = 1'b1;
    tick(2);
    $display("reset: busy=%b send_n=%b rgb=%h", busy, send_n, rgb_data);
  endtask

  task automatic test_basic_frame;
    for (int i = 0; i < N; i++) write_pix(3'(i), 24'h0000FF << ((16 * i) / 7));
    play_frame(1'b1, 8'd255, -1, 1'b0, 24'h0);
    checks += 3;
    if (obs_launch != 3) begin failures++; $display("FAIL basic_launch: got %0d cycles expected 3", obs_launch); end
    if (obs_busy_start !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b expected 1", obs_busy_start); end
    if (obs_tail != TAIL) begin failures++; $display("FAIL basic_tail: got %0d expected %0d", obs_tail, TAIL); end
    for (int k = 0; k < N; k++) begin
      checks += 3;
      if (obs_rgb[k] !== scale_ref(model_mem[k], 8'd255)) begin
        failures++; $display("FAIL basic_rgb[%0d]: got %h expected %h", k, obs_rgb[k], scale_ref(model_mem[k], 8'd255));
      end
      if (obs_sendn[k] !== (k == N - 1)) begin
        failures++; $display("FAIL basic_send_n[%0d]: got %b expected %b", k, obs_sendn[k], (k == N - 1));
      end
      if (obs_stable[k] !== 1'b1) begin failures++; $display("FAIL basic_stable[%0d]: got 0 expected 1", k); end
      $display("basic pixel %0d: rgb=%h send_n=%b", k, obs_rgb[k], obs_sendn[k]);
    end
    checks += 2;
    if (obs_busy_done !== 1'b0) begin failures++; $display("FAIL basic_busy_done: got %b expected 0", obs_busy_done); end
    tick(1);
    if (frame_done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: got %b expected 0", frame_done); end
  endtask

  task automatic test_scaling;
    write_pix(3'd0, 24'h80FF10);
    for (int i = 1; i < N; i++) write_pix(3'(i), 24'($urandom));
    play_frame(1'b1, 8'd128, -1, 1'b0, 24'h0);
    checks++;
    if (obs_rgb[0] !== 24'h408008) begin failures++; $display("FAIL scale128_fixed: got %h expected 408008", obs_rgb[0]); end
    for (int k = 1; k < N; k++) begin
      checks++;
      if (obs_rgb[k] !== scale_ref(model_mem[k], 8'd128)) begin
        failures++; $display("FAIL scale128[%0d]: got %h expected %h", k, obs_rgb[k], scale_ref(model_mem[k], 8'd128));
      end
    end
    $display("scale 128: pixel0=%h", obs_rgb[0]);
    play_frame(1'b1, 8'd0, -1, 1'b0, 24'h0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (obs_rgb[k] !== 24'h0) begin failures++; $display("FAIL scale0[%0d]: got %h expected 000000", k, obs_rgb[k]); end
    end
    $display("scale 0: pixel0=%h", obs_rgb[0]);
  endtask

  task automatic test_random;
    logic [7:0] b;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N; i++) write_pix(3'(i), 24'($urandom));
      b = 8'($urandom);
      play_frame(1'b1, b, -1, 1'b0, 24'h0);
      for (int k = 0; k < N; k++) begin
        checks++;
        if (obs_rgb[k] !== scale_ref(model_mem[k], b)) begin
          failures++; $display("FAIL random%0d_rgb[%0d]: got %h expected %h", f, k, obs_rgb[k], scale_ref(model_mem[k], b));
        end
      end
      checks++;
      if (obs_tail != TAIL) begin failures++; $display("FAIL random%0d_tail: got %0d expected %0d", f, obs_tail, TAIL); end
      $display("random frame %0d: b=%0d pixel7=%h", f, b, obs_rgb[N-1]);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b2;
    b2 = 8'($urandom);
    play_frame(1'b1, 8'd255, 3, 1'b0, 24'h0);
    checks++;
    if (obs_tail != TAIL) begin failures++; $display("FAIL b2b_first_tail: got %0d expected %0d", obs_tail, TAIL); end
    // The queued frame must be accepted at the edge right after frame_done.
    play_frame(1'b0, b2, -1, 1'b0, 24'h0);
    checks += 2;
    if (obs_busy_start !== 1'b1) begin failures++; $display("FAIL b2b_pending_start: got %b expected 1", obs_busy_start); end
    if (obs_launch != 3) begin failures++; $display("FAIL b2b_pending_launch: got %0d expected 3", obs_launch); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (obs_rgb[k] !== scale_ref(model_mem[k], b2)) begin
        failures++; $display("FAIL b2b_rgb[%0d]: got %h expected %h", k, obs_rgb[k], scale_ref(model_mem[k], b2));
      end
    end
    tick(40);
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_no_third_frame: got busy=%b expected 0", busy); end
    if (send_n !== 1'b1) begin failures++; $display("FAIL b2b_idle_send_n: got %b expected 1", send_n); end
    $display("back-to-back: second frame launch=%0d busy after=%b", obs_launch, busy);
  endtask

  task automatic test_reset_midframe;
    int n;
    brightness = 8'd255;
    start = 1'b1; tick(1); start = 1'b0;
    n = 0;
    while (send_n && n < 10) begin tick(1); n++; end
    for (int k = 0; k < 4; k++) begin
      new_data_req = 1'b1; tick(1); new_data_req = 1'b0; tick(5);
    end
    checks++;
    if (rgb_data !== model_mem[3]) begin failures++; $display("FAIL midreset_pixel3: got %h expected %h", rgb_data, model_mem[3]); end
    reset_n = 1'b0;
    #1;
    checks += 3;
    if (send_n !== 1'b1) begin failures++; $display("FAIL midreset_send_n: got %b expected 1", send_n); end
    if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    if (rgb_data !== 24'h0) begin failures++; $display("FAIL midreset_rgb: got %h expected 000000", rgb_data); end
    $display("reset mid-stream: send_n=%b busy=%b rgb=%h", send_n, busy, rgb_data);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    play_frame(1'b1, 8'd255, -1, 1'b0, 24'h0);
    checks++;
    if (obs_launch != 3) begin failures++; $display("FAIL postreset_launch: got %0d expected 3", obs_launch); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (obs_rgb[k] !== model_mem[k]) begin failures++; $display("FAIL postreset_rgb[%0d]: got %h expected %h", k, obs_rgb[k], model_mem[k]); end
    end
  endtask

  task automatic test_midframe_write;
    logic [23:0] old5, w;
    logic [23:0] exp5;
    old5 = model_mem[5];
    w = 24'($urandom);
    if (w == old5) w = ~old5;
    play_frame(1'b1, 8'd255, -1, 1'b1, w);
    model_mem[5] = w;
`ifdef WS2812_DOUBLE_BUFFER_EN
    exp5 = old5;
`else
    exp5 = w;
`endif
    checks++;
    if (obs_rgb[5] !== exp5) begin failures++; $display("FAIL midwrite_current: got %h expected %h", obs_rgb[5], exp5); end
    play_frame(1'b1, 8'd255, -1, 1'b0, 24'h0);
    checks++;
    if (obs_rgb[5] !== w) begin failures++; $display("FAIL midwrite_next: got %h expected %h", obs_rgb[5], w); end
    $display("mid-frame write: current=%h next=%h", exp5, obs_rgb[5]);
  endtask

  task automatic test_single_led;
    logic [23:0] a, junk, rgb_hold;
    logic [7:0]  b;
    int n;
    a = 24'($urandom);
    junk = ~a;
    b = 8'($urandom);
    pix_we1 = 1'b1; pix_addr1 = 1'b0; pix_wdata1 = a; tick(1);
    pix_addr1 = 1'b1; pix_wdata1 = junk; tick(1);
    pix_we1 = 1'b0;
    brightness1 = b;
    start1 = 1'b1; tick(1); start1 = 1'b0;
    n = 0;
    while (send_n1 && n < 10) begin tick(1); n++; end
    checks++;
    if (n != 3) begin failures++; $display("FAIL single_launch: got %0d expected 3", n); end
    new_data_req1 = 1'b1; tick(1); new_data_req1 = 1'b0;
    checks++;
    if (send_n1 !== 1'b1) begin failures++; $display("FAIL single_send_n: got %b expected 1", send_n1); end
    tick(3);
    checks += 2;
    if (rgb_data1 !== scale_ref(a, b)) begin failures++; $display("FAIL single_rgb: got %h expected %h", rgb_data1, scale_ref(a, b)); end
    if (busy1 !== 1'b1) begin failures++; $display("FAIL single_busy: got %b expected 1", busy1); end
    n = 3;
    while (!frame_done1 && n < TAIL + 20) begin tick(1); n++; end
    checks++;
    if (n != TAIL) begin failures++; $display("FAIL single_tail: got %0d expected %0d", n, TAIL); end
    tick(1);
    rgb_hold = rgb_data1;
    new_data_req1 = 1'b1; tick(1); new_data_req1 = 1'b0; tick(3);
    checks += 3;
    if (rgb_data1 !== rgb_hold) begin failures++; $display("FAIL single_idle_req_rgb: got %h expected %h", rgb_data1, rgb_hold); end
    if (busy1 !== 1'b0) begin failures++; $display("FAIL single_idle_req_busy: got %b expected 0", busy1); end
    if (send_n1 !== 1'b1) begin failures++; $display("FAIL single_idle_req_send_n: got %b expected 1", send_n1); end
    $display("single led: b=%0d rgb=%h tail=%0d", b, rgb_hold, n);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    pix_we = 1'b0; pix_addr = '0; pix_wdata = '0; brightness = '0;
    start = 1'b0; new_data_req = 1'b0;
    pix_we1 = 1'b0; pix_addr1 = '0; pix_wdata1 = '0; brightness1 = '0;
    start1 = 1'b0; new_data_req1 = 1'b0;
    test_reset;
    test_basic_frame;
    test_scaling;
    test_random;
    test_back_to_back;
    test_reset_midframe;
    test_midframe_write;
    test_single_led;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_sequencer.md
Name: ws2812_frame_sequencer

Overview:
- Frame controller in front of the WS2812 serializer.
- Holds a NUM_LEDS-deep pixel store written by the host and applies a global 8-bit brightness scale.
- On a frame trigger, sequences the serializer's send_n / rgb_data / new_data_req handshake so exactly NUM_LEDS pixels are sent per frame.
- Reports busy and frame completion to the host.

Parameters:
- NUM_LEDS, 8, pixels per frame and pixel-store depth (≥1).
- TAIL_CYCLES, 1500, guard cycles after send_n rises; must be ≥ 24 × 61 so the serializer finishes the last pixel.
- ADDR_W, $clog2(NUM_LEDS) (min 1), pixel address width.

Ports:
- clk  in  1  system clock, 48 MHz.
- reset_n  in  1  asynchronous active-low reset.
- pix_we  in  1  host write strobe.
- pix_addr  in  ADDR_W  host write address.
- pix_wdata  in  24  pixel in wire order, bit 23 sent first.
- brightness  in  8  global scale; sampled at frame start.
- start  in  1  one-cycle frame trigger.
- busy  out  1  frame in progress, including pending and tail.
- frame_done  out  1  one-cycle pulse at end of tail.
- rgb_data  out  24  scaled pixel to serializer.
- send_n  out  1  active-low "more pixels" to serializer.
- new_data_req  in  1  serializer pulse at the start of each pixel.

Behaviour:
- Reset: busy=0, frame_done=0, rgb_data=0, send_n=1, state IDLE, pending=0, edge-detect register=0. Pixel store is not cleared.
- Reset mid-frame: send_n returns high asynchronously, and the serializer is reset by the same reset_n.
- Pixel store: writes are synchronous (pix_we, addr < NUM_LEDS); addr ≥ NUM_LEDS is ignored. Reads are synchronous with 1-cycle latency.
- Scale: each 8-bit channel c maps to (c × (bright_q + 1)) >> 8, where bright_q is the frame-latched brightness. 255 is identity and 0 yields 0. Scaling is one registered stage.
- Edge: req_rise = new_data_req & ~new_data_req_q.
- State IDLE:
  - On start (or pending set), latch brightness into bright_q, set idx=0, busy=1, clear pending, issue read of pixel 0, go to LOAD.
- State LOAD (2 cycles: read + scale):
  - Write rgb_data with scaled pixel 0, then go to ARM.
- State ARM:
  - Drive send_n=0.
  - On req_rise (pixel 0 started): if NUM_LEDS==1, set send_n=1 and go to TAIL; else set idx=1 and go to STREAM.
- State STREAM:
  - On each req_rise: read pixel idx and update rgb_data ≤4 cycles after the new_data_req rising edge, well inside the 17-cycle data-independent high window.
  - If idx==NUM_LEDS-1, set send_n=1 in the same cycle as req_rise and go to TAIL; else idx+1.
  - rgb_data is stable between updates.
- State TAIL:
  - Count TAIL_CYCLES with send_n=1, then pulse frame_done and go to IDLE. busy falls in the same cycle frame_done pulses.
- Timing:
  - send_n falls exactly 3 cycles after an accepted start.
  - Exactly NUM_LEDS req_rise events are consumed per frame.
  - req_rise in IDLE, LOAD or TAIL is ignored.
- start while busy: sets pending, one-deep; further starts are dropped.
  - The pending frame begins in IDLE the cycle after frame_done.
  - start on the frame_done cycle also sets pending.
- Writes during a frame: allowed. A pixel not yet read shows the new value (tearing permitted without the optional feature).
- brightness changes mid-frame: no effect until the next frame.

Optional Feature:
- Macro: WS2812_DOUBLE_BUFFER_EN.
- With the macro:
  - Two banks. Host writes go to the back bank.
  - At frame accept (IDLE→LOAD) the banks swap and the back bank is copied forward in the background (one pixel per cycle, ignoring host writes to the copied address in that cycle), so the streamed frame is tear-free.
  - Output swap_pending_o is absent; behaviour is otherwise identical.
- Without the macro: single bank, as above.

Decomposition:
- Package ws2812_pkg:
  - PIXEL_W=24, CHAN_W=8, T_PERIOD=60, T0_ON=17, T1_ON=34, T_RESET=3120.
  - State enum {IDLE, LOAD, ARM, STREAM, TAIL}.
  - Function scale_chan(c, b).
- Sub-module ws2812_pixel_scaler: 24-bit in, 8-bit brightness, one registered stage.

Test Plan:
- Write pixels 0..7 = 24'h0000FF…24'hFF0000 with brightness=255, then start → send_n falls 3 cycles later. After each of 8 req_rise, rgb_data equals the stored pixel within 4 cycles. send_n rises on the 8th req_rise. frame_done arrives TAIL_CYCLES later.
- brightness=128, pixel 24'h80FF10 → rgb_data=24'h408008. brightness=0 → 24'h000000.
- start pulsed during STREAM, plus a second extra start → exactly one additional frame begins the cycle after frame_done.
- Assert reset_n mid-STREAM (pixel 3) → send_n=1, busy=0, rgb_data=0 immediately. A subsequent start sends all 8 pixels from index 0.
- NUM_LEDS=1 → send_n rises on the first req_rise. Exactly one pixel is streamed.
- WS2812_DOUBLE_BUFFER_EN: overwrite pixel 5 during STREAM at idx=2 → the current frame shows the old value and the next frame shows the new value.
